lfsr_prng_param: RTL and testbench

Parametrised successor to the 4-bit universal PRNG register: a WIDTH-bit Fibonacci LFSR with a programmable tap mask and the same four modes (hold, complement, right-shift with feedback, left-shift with feedback). It adds clock enable, synchronous seed load, all-zero lockup recovery, and period tracking (step counter plus wrap pulse). It sits in the PRNG datapath as the random source feeding downstream consumers in parallel or via the serial edge taps.

---
 rtl/lfsr_prng_param.sv | 118 +++++++++++
 tb/tb_lfsr_prng_param.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr_prng_param.sv
// Parametrised Fibonacci LFSR PRNG with hold/complement/shift modes, seed load,
// all-zero lockup recovery and period tracking against an anchor state.
module lfsr_prng_param #(
  parameter int unsigned          WIDTH      = 4,
  parameter logic [WIDTH-1:0]     TAPS       = WIDTH'(4'b0011),
  parameter logic [WIDTH-1:0]     RESET_SEED = '1,
  parameter int unsigned          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       select,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] p_dout,
  output logic             s_left_dout,
  output logic             s_right_dout,
  output logic [CNT_W-1:0] step_cnt,
  output logic             wrap,
  output logic             lockup_err
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_COMP = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_SHL  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] anchor_q, anchor_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             lock_q, lock_d;
  logic             fb;
  logic [WIDTH-1:0] shifted;
  mode_e            mode;

  assign mode = mode_e'(select);
  assign fb   = ^(state_q & TAPS);

  always_comb begin
    shifted = state_q;
    if (mode == MODE_SHR) shifted = {fb, state_q[WIDTH-1:1]};
    else                  shifted = {state_q[WIDTH-2:0], fb};
  end

  always_comb begin
    state_d  = state_q;
    anchor_d = anchor_q;
    cnt_d    = cnt_q;
    wrap_d   = 1'b0;
    lock_d   = lock_q;
    if (load) begin
      cnt_d = '0;
      if (seed != '0) begin
        state_d  = seed;
        anchor_d = seed;
        lock_d   = 1'b0;
      end else begin
        state_d  = RESET_SEED;
        anchor_d = RESET_SEED;
        lock_d   = 1'b1;
      end
    end else if (en) begin
      unique case (mode)
        MODE_HOLD: ;
        MODE_COMP: begin
          state_d  = ~state_q;
          anchor_d = ~state_q;
          cnt_d    = '0;
        end
        MODE_SHR, MODE_SHL: begin
          // A zero state never leaves zero under XOR feedback, so reseed instead of shifting.
          if (state_q == '0) begin
            state_d  = RESET_SEED;
            anchor_d = RESET_SEED;
            cnt_d    = '0;
            lock_d   = 1'b1;
          end else begin
            state_d = shifted;
            if (shifted == anchor_q) begin
              wrap_d = 1'b1;
              cnt_d  = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RESET_SEED;
      anchor_q <= RESET_SEED;
      cnt_q    <= '0;
      wrap_q   <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      anchor_q <= anchor_d;
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
      lock_q   <= lock_d;
    end
  end

  assign p_dout       = state_q;
  assign s_left_dout  = state_q[0];
  assign s_right_dout = state_q[WIDTH-1];
  assign step_cnt     = cnt_q;
  assign wrap         = wrap_q;
  assign lockup_err   = lock_q;

endmodule

// File: tb/tb_lfsr_prng_param.sv
// Self-checking bench for lfsr_prng_param: behavioural model compared every cycle,
// plus directed literal expectations and randomized traffic.
module tb_lfsr_prng_param;

  localparam int unsigned W     = 4;
  localparam int unsigned CW    = 16;
  localparam logic [W-1:0] TAPS = 4'b0011;
  localparam logic [W-1:0] RS   = 4'b1111;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    select = 2'b00;
  logic          load = 1'b0;
  logic [W-1:0]  seed = '0;
  logic [W-1:0]  p_dout;
  logic          s_left_dout, s_right_dout;
  logic [CW-1:0] step_cnt;
  logic          wrap, lockup_err;

  int checks = 0;
  int errors = 0;

  lfsr_prng_param #(.WIDTH(W), .TAPS(TAPS), .RESET_SEED(RS), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .select(select), .load(load), .seed(seed),
    .p_dout(p_dout), .s_left_dout(s_left_dout), .s_right_dout(s_right_dout),
    .step_cnt(step_cnt), .wrap(wrap), .lockup_err(lockup_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: integer state, anchor and counter stepped by the mode rules.
  int unsigned m_st = 15, m_an = 15, m_cnt = 0;
  bit          m_wr = 0, m_lk = 0;

  always @(posedge clk or posedge rst) begin
    int unsigned fb, nx;
    if (rst) begin
      m_st = RS; m_an = RS; m_cnt = 0; m_wr = 0; m_lk = 0;
    end else begin
      m_wr = 0;
      if (load) begin
        m_cnt = 0;
        if (seed != 0) begin m_st = seed; m_an = seed; m_lk = 0; end
        else begin m_st = RS; m_an = RS; m_lk = 1; end
      end else if (en) begin
        if (select == 2'd1) begin
          m_st = 15 - m_st; m_an = m_st; m_cnt = 0;
        end else if (select != 2'd0) begin
          if (m_st == 0) begin
            m_st = RS; m_an = RS; m_cnt = 0; m_lk = 1;
          end else begin
            fb = $countones(m_st & TAPS) % 2;
            if (select == 2'd2) nx = (m_st / 2) + fb * 8;
            else                nx = (m_st * 2 + fb) % 16;
            m_st = nx;
            if (nx == m_an) begin m_wr = 1; m_cnt = 0; end
            else m_cnt = (m_cnt + 1) % 65536;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Single compare process against the model, away from the active edge.
  always @(negedge clk) begin
    chk("p_dout", p_dout, m_st);
    chk("s_left", s_left_dout, m_st % 2);
    chk("s_right", s_right_dout, m_st / 8);
    chk("step_cnt", step_cnt, m_cnt);
    chk("wrap", wrap, m_wr);
    chk("lockup_err", lockup_err, m_lk);
  end

  task automatic tick(input logic e, input logic [1:0] s, input logic l, input logic [W-1:0] sd);
    en = e; select = s; load = l; seed = sd;
    @(posedge clk);
    #2;
  endtask

  logic [W-1:0] shr_exp [15];
  logic [W-1:0] shl_exp [3];
  logic [W-1:0] p_keep;
  logic [CW-1:0] c_keep;

  initial begin
    shr_exp = '{4'b0111, 4'b0011, 4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b1001, 4'b1100,
                4'b0110, 4'b1011, 4'b0101, 4'b1010, 4'b1101, 4'b1110, 4'b1111};
    shl_exp = '{4'b1110, 4'b1101, 4'b1011};

    #1 rst = 1'b1;
    @(posedge clk); #2;
    chk("rst_p_dout", p_dout, 15);
    chk("rst_step_cnt", step_cnt, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_lockup", lockup_err, 0);
    rst = 1'b0;

    // Full right-shift period from the reset seed
    for (int i = 0; i < 15; i++) begin
      tick(1'b1, 2'b10, 1'b0, '0);
      chk("shr_seq", p_dout, shr_exp[i]);
      if (i == 13) chk("shr_cnt_before_wrap", step_cnt, 14);
      if (i == 13) chk("shr_no_wrap_early", wrap, 0);
    end
    chk("shr_wrap", wrap, 1);
    chk("shr_wrap_cnt", step_cnt, 0);
    tick(1'b0, 2'b10, 1'b0, '0);
    chk("wrap_pulse_end", wrap, 0);

    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 2'b11, 1'b0, '0);
      chk("shl_seq", p_dout, shl_exp[i]);
      chk("shl_s_left", s_left_dout, shl_exp[i][0]);
      chk("shl_s_right", s_right_dout, shl_exp[i][3]);
    end

    tick(1'b1, 2'b10, 1'b1, 4'b0000);
    chk("zero_seed_p", p_dout, 15);
    chk("zero_seed_lock", lockup_err, 1);
    tick(1'b0, 2'b00, 1'b1, 4'b0101);
    chk("seed_p", p_dout, 5);
    chk("seed_lock_clr", lockup_err, 0);
    chk("seed_cnt", step_cnt, 0);

    tick(1'b0, 2'b00, 1'b1, 4'b1111);
    tick(1'b1, 2'b01, 1'b0, '0);
    chk("comp_zero", p_dout, 0);
    chk("comp_no_lock", lockup_err, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 2'b00, 1'b0, '0);
      chk("hold_zero", p_dout, 0);
    end
    tick(1'b1, 2'b10, 1'b0, '0);
    chk("recover_p", p_dout, 15);
    chk("recover_lock", lockup_err, 1);
    chk("recover_no_wrap", wrap, 0);

    tick(1'b1, 2'b10, 1'b0, '0);
    tick(1'b1, 2'b10, 1'b0, '0);
    p_keep = p_dout; c_keep = step_cnt;
    chk("pre_en0_p", p_keep, 3);
    chk("pre_en0_cnt", c_keep, 2);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 2'b10, 1'b0, '0);
      chk("en0_p", p_dout, 3);
      chk("en0_cnt", step_cnt, 2);
    end

    rst = 1'b1;
    #1;
    chk("async_rst_p", p_dout, 15);
    chk("async_rst_cnt", step_cnt, 0);
    chk("async_rst_wrap", wrap, 0);
    chk("async_rst_lock", lockup_err, 0);
    #1 rst = 1'b0;

    tick(1'b1, 2'b11, 1'b1, 4'b1010);
    chk("load_beats_shift", p_dout, 10);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1; #1 rst = 1'b0;
      end
      tick($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           $urandom_range(0, 15) == 0, W'($urandom_range(0, 15)));
    end

    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
